// File: rtl/adc_spi_slave.sv
// rtl/adc_spi_slave.sv - SPI mode-0 register-access slave for the SAR ADC block
// Frames are 16 bits MSB first: {cmd[1:0], addr[1:0], data[11:0]}.
module adc_spi_slave (
  input  logic clk,
  input  logic reset_,
  input  logic sck,
  input  logic cs,
  input  logic mosi,
  output logic miso
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_EXEC} state_e;

  localparam logic [11:0] STATUS_VAL = 12'h800;
  localparam logic [11:0] DATA_VAL   = 12'h000;

  state_e      state_q, state_d;
  logic [1:0]  sck_sync_q, cs_sync_q, mosi_sync_q;
  logic        sck_prev_q;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] rx_q, rx_d;
  logic [11:0] tx_q, tx_d;
  logic [11:0] ctrl_q, ctrl_d;
  logic [11:0] offset_q, offset_d;
  logic        sck_s, cs_s, mosi_s, rise, fall;
  logic [11:0] exec_cur, exec_new, tx_val;

  function automatic logic [11:0] reg_rd(input logic [1:0] a, input logic [11:0] c,
                                         input logic [11:0] o);
    case (a)
      2'd0:    reg_rd = c;
      2'd1:    reg_rd = STATUS_VAL;
      2'd2:    reg_rd = DATA_VAL;
      default: reg_rd = o;
    endcase
  endfunction

  assign sck_s  = sck_sync_q[1];
  assign cs_s   = cs_sync_q[1];
  assign mosi_s = mosi_sync_q[1];
  assign rise   = sck_s & ~sck_prev_q & ~cs_s;
  assign fall   = ~sck_s & sck_prev_q & ~cs_s;
  assign miso   = tx_q[11];

  assign exec_cur = reg_rd(rx_q[13:12], ctrl_q, offset_q);
  assign tx_val   = reg_rd(rx_q[1:0], ctrl_q, offset_q);

  always_comb begin
    case (rx_q[15:14])
      2'b01:   exec_new = rx_q[11:0];
      2'b10:   exec_new = exec_cur | rx_q[11:0];
      2'b11:   exec_new = exec_cur & ~rx_q[11:0];
      default: exec_new = exec_cur;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rx_d     = rx_q;
    ctrl_d   = ctrl_q;
    offset_d = offset_q;
    case (state_q)
      S_EXEC: begin
        if (!cs_s) begin
          if (rx_q[13:12] == 2'd0) ctrl_d = exec_new;
          if (rx_q[13:12] == 2'd3) offset_d = exec_new;
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        if (cs_s) begin
          state_d = S_IDLE;
          cnt_d   = 5'd0;
        end else begin
          state_d = S_SHIFT;
          if (rise) begin
            rx_d = {rx_q[14:0], mosi_s};
            if (cnt_q == 5'd15) begin
              cnt_d   = 5'd0;
              state_d = S_EXEC;
            end else begin
              cnt_d = cnt_q + 5'd1;
            end
          end
        end
      end
    endcase
  end

  // TX register: loaded once addr is known (4th fall), zero outside the data phase
  always_comb begin
    tx_d = tx_q;
    if (cs_s) begin
      tx_d = 12'h000;
    end else if (fall) begin
      if (cnt_q == 5'd4)
        tx_d = tx_val;
      else if (cnt_q >= 5'd5 && cnt_q <= 5'd15)
        tx_d = {tx_q[10:0], 1'b0};
      else
        tx_d = 12'h000;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q     <= S_IDLE;
      sck_sync_q  <= 2'b00;
      cs_sync_q   <= 2'b11;
      mosi_sync_q <= 2'b00;
      sck_prev_q  <= 1'b0;
      cnt_q       <= 5'd0;
      rx_q        <= 16'h0000;
      tx_q        <= 12'h000;
      ctrl_q      <= 12'h000;
      offset_q    <= 12'h000;
    end else begin
      state_q     <= state_d;
      sck_sync_q  <= {sck_sync_q[0], sck};
      cs_sync_q   <= {cs_sync_q[0], cs};
      mosi_sync_q <= {mosi_sync_q[0], mosi};
      sck_prev_q  <= sck_s;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      ctrl_q      <= ctrl_d;
      offset_q    <= offset_d;
    end
  end

endmodule

// File: tb/tb_adc_spi_slave.sv
// tb/tb_adc_spi_slave.sv - scoreboard bench for adc_spi_slave
module tb_adc_spi_slave;

  logic clk = 1'b0;
  logic reset_, sck, cs, mosi, miso;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];
  logic [11:0] m_ctrl, m_offset;

  adc_spi_slave dut (
    .clk(clk), .reset_(reset_), .sck(sck), .cs(cs), .mosi(mosi), .miso(miso)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%04h exp=0x%04h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [11:0] model_rd(input logic [1:0] a);
    case (a)
      2'd0:    return m_ctrl;
      2'd1:    return 12'h800;
      2'd2:    return 12'h000;
      default: return m_offset;
    endcase
  endfunction

  task automatic model_apply(input logic [15:0] f);
    logic [11:0] cur, nv;
    cur = model_rd(f[13:12]);
    case (f[15:14])
      2'b01:   nv = f[11:0];
      2'b10:   nv = cur | f[11:0];
      2'b11:   nv = cur & ~f[11:0];
      default: nv = cur;
    endcase
    if (f[13:12] == 2'd0) m_ctrl = nv;
    if (f[13:12] == 2'd3) m_offset = nv;
  endtask

  task automatic spi_frame(input logic [15:0] f, input int nbits, input bit hold_cs,
                           output logic [15:0] rx);
    rx = 16'h0000;
    if (cs) begin
      cs = 1'b0;
      wait_clk(8);
    end
    for (int i = 0; i < nbits; i++) begin
      mosi = f[15-i];
      wait_clk(8);
      sck = 1'b1;
      wait_clk(8);
      rx = {rx[14:0], miso};
      sck = 1'b0;
    end
    wait_clk(8);
    if (!hold_cs) begin
      cs = 1'b1;
      wait_clk(8);
    end
  endtask

  task automatic do_frame(input string tag, input logic [15:0] f, input bit hold_cs);
    logic [15:0] got;
    exp_q.push_back({4'h0, model_rd(f[13:12])});
    model_apply(f);
    spi_frame(f, 16, hold_cs, got);
    check(tag, got, exp_q.pop_front());
    if (!hold_cs) check({tag, "_miso_idle"}, {15'h0, miso}, 16'h0000);
  endtask

  initial begin
    logic [15:0] dummy;
    logic [15:0] rf;
    reset_ = 1'b0; cs = 1'b1; sck = 1'b0; mosi = 1'b0;
    m_ctrl = 12'h000; m_offset = 12'h000;
    wait_clk(5);
    check("reset_miso", {15'h0, miso}, 16'h0000);
    reset_ = 1'b1;
    wait_clk(5);

    do_frame("rd_status", 16'h1000, 1'b0);
    do_frame("wr_ctrl_a5a", 16'h4A5A, 1'b0);
    do_frame("rd_ctrl_a5a", 16'h0000, 1'b0);
    do_frame("wr_ctrl_c33", 16'h4C33, 1'b0);
    do_frame("set_ctrl", 16'h80F0, 1'b0);
    do_frame("rd_ctrl_cf3", 16'h0000, 1'b0);
    do_frame("wr_ctrl_cf3", 16'h4CF3, 1'b0);
    do_frame("clr_ctrl", 16'hCC0C, 1'b0);
    do_frame("rd_ctrl_0f3", 16'h0000, 1'b0);
    do_frame("wr_status", 16'h5BAD, 1'b0);
    do_frame("rd_status_ro", 16'h1000, 1'b0);
    do_frame("b2b_wr", 16'h4CDE, 1'b1);
    do_frame("b2b_rd", 16'h0000, 1'b0);

    do_frame("wr_ctrl_123", 16'h4123, 1'b0);
    spi_frame(16'h4FFF, 10, 1'b0, dummy);
    check("abort_miso_idle", {15'h0, miso}, 16'h0000);
    do_frame("rd_after_abort", 16'h0000, 1'b0);

    for (int i = 0; i < 20; i++) begin
      mosi = i[0];
      wait_clk(6);
      sck = 1'b1;
      wait_clk(6);
      sck = 1'b0;
      check("cs_high_miso", {15'h0, miso}, 16'h0000);
    end
    do_frame("rd_status_idle", 16'h1000, 1'b0);
    do_frame("rd_data", 16'h2000, 1'b0);
    do_frame("rd_offset", 16'h3000, 1'b0);
    do_frame("wr_offset", 16'h7ABC, 1'b0);
    do_frame("rd_offset_abc", 16'h3000, 1'b0);
    do_frame("wr_data_ro", 16'h6FFF, 1'b0);
    do_frame("rd_data_ro", 16'h2000, 1'b0);

    for (int i = 0; i < 12; i++) begin
      rf = 16'($urandom);
      do_frame("rand", rf, (i % 3) == 1);
    end
    do_frame("rd_ctrl_end", 16'h0000, 1'b0);
    do_frame("rd_offset_end", 16'h3000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
